nibble_serial_addsub: RTL and testbench
=======================================

# nibble_serial_addsub

Multi-cycle add/subtract controller that sequences a single 4-bit add/sub slice across a W = 4·NIBBLES-bit operand pair, least-significant nibble first, chaining the carry through a register between cycles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades latency for area: one 4-bit slice in place of a full-width adder.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; legal range 1..8; W = 4·NIBBLES
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start_valid  in  1  operand request
- start_ready  out  1  high only in IDLE; an operation is accepted on an edge where start_valid & start_ready
- a  in  W  operand A, sampled at accept
- b  in  W  operand B, sampled at accept
- m  in  1  0 = A+B, 1 = A−B; sampled at accept
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result on an edge where res_valid & res_ready
- result  out  W  A+B or A−B, modulo 2^W
- cout  out  1  carry out of the top bit; for subtract, 1 = no borrow
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - start_ready = 1.
  - On accept: latch a, b and m; set the carry register to m; set the nibble index to 0; go to RUN.
- RUN, one nibble per cycle. Nibble i computes sum_i = a[4i+3:4i] + (b[4i+3:4i] XOR {4{m}}) + carry.
  - The sum is stored into bits [4i+3:4i] of the partial-result register.
  - carry ← c3, the carry out of the slice's bit 3.
  - The index increments. It never wraps; the last index is NIBBLES−1.
- On the last nibble:
  - result ← the full partial result, including the last nibble.
  - cout ← c3 of that nibble.
  - overflow ← c2 XOR c3 of that nibble.
  - Go to DONE.
- DONE
  - res_valid = 1.
  - result, cout and overflow are held stable until the handshake.
  - On res_valid & res_ready: go to IDLE.
- start_ready is 0 in RUN and DONE. start_valid in those states is ignored and not queued.
- a, b and m changing after accept have no effect on the operation in flight.
- result, cout and overflow change only on the RUN→DONE edge or on reset. Between operations they keep their last values.
- Reset (rst_n low at an edge), from any state including mid-RUN or DONE:
  - State goes to IDLE, nibble index 0, carry 0.
  - result = 0, cout = 0, overflow = 0, res_valid = 0, busy = 0, start_ready = 1.
  - The in-flight operation is discarded and is never reported.
- Reset takes priority over every simultaneous handshake.

## Timing
- Accept edge E0; RUN is active for NIBBLES cycles; res_valid goes high after edge E_NIBBLES.
  - Accept-to-valid latency is NIBBLES clocks; 4 clocks at the default.
- With res_ready held at 1, the result is consumed on edge E_NIBBLES+1.
  - start_ready is high again from that point, so the next accept can occur at E_NIBBLES+2.
  - Maximum throughput is one operation per NIBBLES+2 clocks.
- NIBBLES=1: a single RUN cycle; the latency is 1.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Test plan
All scenarios use NIBBLES=4.
- Add: a=0x1234, b=0x0FFF, m=0 → result=0x2233, cout=0, overflow=0; res_valid exactly 4 clocks after the accept edge.
- Subtract with borrow: a=0x0005, b=0x0007, m=1 → result=0xFFFE, cout=0, overflow=0. Then a=0xFFFF, b=0x0001, m=0 → result=0x0000, cout=1, overflow=0.
- Overflow:
  - a=0x7FFF, b=0x0001, m=0 → result=0x8000, cout=0, overflow=1.
  - a=0x8000, b=0x0001, m=1 → result=0x7FFF, cout=1, overflow=1.
- Backpressure:
  - After a=0x00FF + b=0x0001 completes, hold res_ready=0 for 6 clocks while driving start_valid=1 with new operands → result stays 0x0100, start_ready=0, no second accept.
  - Raise res_ready → return to IDLE, then the new operands are accepted.
- Operand isolation: accept a=0x1111, b=0x2222, m=0, then change a, b and m every RUN cycle → result=0x3333.
- Reset mid-operation:
  - Pull rst_n low during the 2nd RUN cycle of a=0xABCD + b=0x1111 → at the next edge res_valid=0, result=0, busy=0, start_ready=1.
  - The discarded result never appears.
  - Next operation a=0x0001, b=0x0001, m=0 → result=0x0002.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// nibble_serial_addsub
//
// Multi-cycle adder/subtractor. Instead of a full-width adder, it has one
// 4-bit add/sub slice. The slice is stepped across a W = 4*NIBBLES bit
// operand pair, least-significant nibble first. The carry is held in a
// register between cycles. There is a valid/ready handshake on both the
// operand side and the result side.
//
// Parameters
//   NIBBLES     number of 4-bit slices per operation (1..8)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous, active-low reset
//   start_valid  operand request
//   start_ready  high only while idle; accept = start_valid & start_ready
//   a, b         W-bit operands, captured at accept
//   m            0 = a+b, 1 = a-b, captured at accept
//   res_valid    result available (DONE state)
//   res_ready    consumer takes the result on res_valid & res_ready
//   result       a+b or a-b modulo 2^W
//   cout         carry out of the top bit (for subtract, 1 = no borrow)
//   overflow     two's-complement overflow of the top bit
//   busy         high while an operation is running or waiting to be taken
// ---------------------------------------------------------------------------
module nibble_serial_addsub #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic         busy
);

    // The nibble index is always 3 bits wide, which covers the full legal
    // range of NIBBLES. Nibble lanes at or above NIBBLES are tied to zero,
    // so the index mux below is always an 8:1 mux for any NIBBLES.
    localparam int          MAX_NIBBLES = 8;
    localparam logic [2:0]  LAST_IDX    = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [2:0]     idx_reg;
    logic           carry_reg;
    logic           m_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   partial_reg;
    logic [W-1:0]   result_reg;
    logic           cout_reg;
    logic           overflow_reg;

    // -----------------------------------------------------------------------
    // Operand nibble lanes
    // -----------------------------------------------------------------------
    logic [3:0] a_nib [MAX_NIBBLES];
    logic [3:0] b_nib [MAX_NIBBLES];

    generate
        for (genvar gi = 0; gi < MAX_NIBBLES; gi++) begin : g_lane
            if (gi < NIBBLES) begin : g_used
                assign a_nib[gi] = a_reg[4*gi +: 4];
                assign b_nib[gi] = b_reg[4*gi +: 4];
            end else begin : g_unused
                assign a_nib[gi] = 4'h0;
                assign b_nib[gi] = 4'h0;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // The shared 4-bit slice
    // -----------------------------------------------------------------------
    logic [3:0] a_cur;
    logic [3:0] b_cur;
    logic [3:0] low_sum;
    logic [4:0] full_sum;
    logic [3:0] sum;
    logic       c2;
    logic       c3;
    logic       last;

    assign a_cur = a_nib[idx_reg];
    // Subtract is implemented as A + ~B + 1. The +1 comes from the carry
    // register, which is seeded with m when the operation is accepted.
    assign b_cur = b_nib[idx_reg] ^ {4{m_reg}};

    // The carry into bit 3 (c2) is needed for the overflow flag. It is
    // taken from a 3-bit add of the low bits, because it is not visible in
    // the 4-bit sum.
    assign low_sum  = {1'b0, a_cur[2:0]} + {1'b0, b_cur[2:0]} + {3'b000, carry_reg};
    assign full_sum = {1'b0, a_cur} + {1'b0, b_cur} + {4'b0000, carry_reg};
    assign c2       = low_sum[3];
    assign c3       = full_sum[4];
    assign sum      = full_sum[3:0];
    assign last     = (idx_reg == LAST_IDX);

    // -----------------------------------------------------------------------
    // Partial result with the current nibble merged in. On the last nibble,
    // this vector (not partial_reg) is copied into the result. This means
    // the top nibble does not need an extra cycle to arrive.
    // -----------------------------------------------------------------------
    logic [W-1:0] partial_next;

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_merge
            assign partial_next[4*gi +: 4] =
                (idx_reg == 3'(gi)) ? sum : partial_reg[4*gi +: 4];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            carry_reg    <= 1'b0;
            m_reg        <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            partial_reg  <= '0;
            result_reg   <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        m_reg     <= m;
                        carry_reg <= m;
                        idx_reg   <= 3'd0;
                        state_reg <= RUN;
                    end
                end

                RUN: begin
                    partial_reg <= partial_next;
                    carry_reg   <= c3;
                    if (last) begin
                        result_reg   <= partial_next;
                        cout_reg     <= c3;
                        overflow_reg <= c2 ^ c3;
                        state_reg    <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Each one is either a register or decoded from the state
    // register only, so no input reaches an output combinationally.
    // -----------------------------------------------------------------------
    assign start_ready = (state_reg == IDLE);
    assign res_valid   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign result      = result_reg;
    assign cout        = cout_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          m;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Each scoreboard entry is {result, cout, overflow}.
    logic [W+1:0] exp_q [$];

    nibble_serial_addsub #(.NIBBLES(NIB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .m           (m),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation for every result handshake.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got result=%h cout=%0b ovf=%0b, required no result",
                         result, cout, overflow);
            end else begin
                e = exp_q.pop_front();
                if ({result, cout, overflow} !== e) begin
                    errors++;
                    $display("FAIL result_txn: got result=%h cout=%0b ovf=%0b, required result=%h cout=%0b ovf=%0b",
                             result, cout, overflow, e[W+1:2], e[1], e[0]);
                end else begin
                    $display("txn ok: result=%h cout=%0b ovf=%0b", result, cout, overflow);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold start_valid until the accept edge. Returns
    // 1 time unit after the accept edge, with start_valid dropped.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic mm);
        int n;
        a = aa;
        b = bb;
        m = mm;
        start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 40) begin
            step();
            n++;
        end
        if (!start_ready) chk("accept_timeout", 32'(start_ready), 32'd1);
        step();
        start_valid = 1'b0;
    endtask

    // Wait for res_valid, with a bound. If res_ready is high, also step
    // past the consume edge.
    task automatic wait_done();
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        if (!res_valid) chk("done_timeout", 32'(res_valid), 32'd1);
        if (res_ready) step();
    endtask

    logic [W-1:0] va [4] = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb [4] = '{16'h0007, 16'h0001, 16'h0001, 16'h0001};
    logic         vm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] ve [4] = '{{16'hFFFE, 1'b0, 1'b0},
                             {16'h0000, 1'b1, 1'b0},
                             {16'h8000, 1'b0, 1'b1},
                             {16'h7FFF, 1'b1, 1'b1}};

    initial begin
        int n;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b1;
        a           = '0;
        b           = '0;
        m           = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_start_ready", 32'(start_ready), 32'h1);
        rst_n = 1'b1;
        step();

        // Add, with a latency check
        exp_q.push_back({16'h2233, 1'b0, 1'b0});
        issue(16'h1234, 16'h0FFF, 1'b0);
        chk("run_busy", 32'(busy), 32'h1);
        chk("run_start_ready", 32'(start_ready), 32'h0);
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        step();
        chk("idle_after_consume", 32'(start_ready), 32'h1);
        chk("hold_result", 32'(result), 32'h2233);

        // Subtract, carry wrap, and overflow vectors
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ve[i]);
            issue(va[i], vb[i], vm[i]);
            wait_done();
        end

        // Backpressure
        res_ready = 1'b0;
        exp_q.push_back({16'h0100, 1'b0, 1'b0});
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_done();
        a = 16'h0010;
        b = 16'h0020;
        m = 1'b0;
        start_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_result", 32'(result), 32'h0100);
            chk("bp_start_ready", 32'(start_ready), 32'h0);
            chk("bp_res_valid", 32'(res_valid), 32'h1);
        end
        exp_q.push_back({16'h0030, 1'b0, 1'b0});
        res_ready = 1'b1;
        step();
        chk("bp_idle", 32'(start_ready), 32'h1);
        step();
        start_valid = 1'b0;
        chk("bp_second_accept", 32'(busy), 32'h1);
        wait_done();

        // Operand isolation
        exp_q.push_back({16'h3333, 1'b0, 1'b0});
        issue(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = 16'hFFFF - 16'(i);
            b = 16'h8001 + 16'(i);
            m = ~m;
            step();
        end
        a = '0;
        b = '0;
        m = 1'b0;
        wait_done();

        // Reset in the middle of an operation (discarded, nothing pushed)
        issue(16'hABCD, 16'h1111, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_res_valid", 32'(res_valid), 32'h0);
        chk("mid_rst_result", 32'(result), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_start_ready", 32'(start_ready), 32'h1);
        chk("mid_rst_cout", 32'(cout), 32'h0);
        rst_n = 1'b1;
        repeat (8) step();
        chk("no_ghost_result", 32'(res_valid), 32'h0);

        exp_q.push_back({16'h0002, 1'b0, 1'b0});
        issue(16'h0001, 16'h0001, 1'b0);
        wait_done();

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
